// File: rtl/fa4_arith.sv
// fa4_arith: one-cycle registered ADD/SUB/NEG/PASS unit built on a ripple chain of full-adder cells.
// Optional macro FA4_ZERO_FLAG_EN adds a registered 'zero' output that flags a zero result.
module fa4_arith #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic [WIDTH-1:0] result,
    output logic             cout,
    output logic             ovf,
    output logic             out_valid
`ifdef FA4_ZERO_FLAG_EN
    ,
    output logic             zero
`endif
);

    typedef enum logic [1:0] {
        OP_ADD  = 2'b00,
        OP_SUB  = 2'b01,
        OP_NEG  = 2'b10,
        OP_PASS = 2'b11
    } op_e;

    localparam int               MSB      = WIDTH - 1;
    localparam logic [WIDTH-1:0] MOST_NEG = WIDTH'(1) << MSB;

    // Operands fed to the shared adder chain
    logic [WIDTH-1:0] w_x;
    logic [WIDTH-1:0] w_y;
    logic             w_c0;
    logic [WIDTH-1:0] w_sum;
    logic             w_carry_out;

    logic [WIDTH-1:0] w_result_next;
    logic             w_cout_next;
    logic             w_ovf_next;

    logic [WIDTH-1:0] r_result;
    logic             r_cout;
    logic             r_ovf;
    logic             r_out_valid;

    // SUB is a + ~b + 1 and NEG is ~a + 0 + 1, so one adder serves every operation
    always_comb begin
        w_x  = a;
        w_y  = b;
        w_c0 = cin;
        unique case (op_e'(op))
            OP_ADD: begin
                w_x  = a;
                w_y  = b;
                w_c0 = cin;
            end
            OP_SUB: begin
                w_x  = a;
                w_y  = ~b;
                w_c0 = 1'b1;
            end
            OP_NEG: begin
                w_x  = ~a;
                w_y  = '0;
                w_c0 = 1'b1;
            end
            OP_PASS: begin
                w_x  = a;
                w_y  = '0;
                w_c0 = 1'b0;
            end
        endcase
    end

    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_fa
            logic w_cin_bit;
            logic w_cout_bit;
            if (gi == 0) begin : g_first
                assign w_cin_bit = w_c0;
            end else begin : g_rest
                assign w_cin_bit = g_fa[gi-1].w_cout_bit;
            end
            assign w_sum[gi]  = w_x[gi] ^ w_y[gi] ^ w_cin_bit;
            assign w_cout_bit = (w_x[gi] & w_y[gi]) | (w_x[gi] & w_cin_bit) | (w_y[gi] & w_cin_bit);
        end
    endgenerate

    assign w_carry_out = g_fa[WIDTH-1].w_cout_bit;

    always_comb begin
        w_result_next = w_sum;
        w_cout_next   = 1'b0;
        w_ovf_next    = 1'b0;
        unique case (op_e'(op))
            OP_ADD: begin
                w_cout_next = w_carry_out;
                w_ovf_next  = (a[MSB] == b[MSB]) && (w_sum[MSB] != a[MSB]);
            end
            OP_SUB: begin
                w_cout_next = w_carry_out;
                w_ovf_next  = (a[MSB] != b[MSB]) && (w_sum[MSB] != a[MSB]);
            end
            OP_NEG: begin
                // ~a + 1 only carries out when a is zero
                w_cout_next = w_carry_out;
                w_ovf_next  = (a == MOST_NEG);
            end
            OP_PASS: begin
                w_result_next = a;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_result    <= '0;
            r_cout      <= 1'b0;
            r_ovf       <= 1'b0;
            r_out_valid <= 1'b0;
        end else begin
            r_out_valid <= in_valid;
            if (in_valid) begin
                r_result <= w_result_next;
                r_cout   <= w_cout_next;
                r_ovf    <= w_ovf_next;
            end
        end
    end

    assign result    = r_result;
    assign cout      = r_cout;
    assign ovf       = r_ovf;
    assign out_valid = r_out_valid;

`ifdef FA4_ZERO_FLAG_EN
    logic r_zero;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_zero <= 1'b0;
        end else if (in_valid) begin
            r_zero <= (w_result_next == '0);
        end
    end

    assign zero = r_zero;
`endif

endmodule

// File: tb/tb_fa4_arith.sv
// Scoreboard bench for fa4_arith: directed vectors push expectations, a negedge monitor pops and compares.
module tb_fa4_arith;

    localparam int W = 4;

    logic         clk;
    logic         rst;
    logic         in_valid;
    logic [1:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic [W-1:0] result;
    logic         cout;
    logic         ovf;
    logic         out_valid;
`ifdef FA4_ZERO_FLAG_EN
    logic         zero;
`endif

    fa4_arith #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .op        (op),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .result    (result),
        .cout      (cout),
        .ovf       (ovf),
        .out_valid (out_valid)
`ifdef FA4_ZERO_FLAG_EN
        ,
        .zero      (zero)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [W-1:0] res;
        logic         c;
        logic         o;
        logic         z;
    } exp_t;

    typedef struct packed {
        logic [1:0]   op;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         cin;
        logic [W-1:0] res;
        logic         c;
        logic         o;
    } vec_t;

    exp_t exp_q[$];
    exp_t held;
    int   checks;
    int   errors;
    int   pushes;
    int   pops;
    bit   mon_en;

    function automatic exp_t dut_out();
        exp_t v;
        v.res = result;
        v.c   = cout;
        v.o   = ovf;
`ifdef FA4_ZERO_FLAG_EN
        v.z   = zero;
`else
        v.z   = 1'b0;
`endif
        return v;
    endfunction

    task automatic compare(input string name, input exp_t act, input exp_t expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got res=%b cout=%b ovf=%b zero=%b, expected res=%b cout=%b ovf=%b zero=%b",
                     name, act.res, act.c, act.o, act.z, expv.res, expv.c, expv.o, expv.z);
        end
    endtask

    // Monitor: inputs only change just after negedge, so rst seen here is the value the last posedge used
    always @(negedge clk) begin
        if (mon_en) begin
            if (rst) begin
                checks++;
                if (out_valid !== 1'b0) begin
                    errors++;
                    $display("FAIL reset_valid: got out_valid=%b, expected 0", out_valid);
                end
                compare("reset_outputs", dut_out(), '0);
                held = '0;
            end else if (out_valid === 1'b1) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL spurious_valid: got out_valid=1, expected 0 (no op pending)");
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    pops++;
                    compare("result", dut_out(), e);
                    $display("t=%0t out res=%b cout=%b ovf=%b", $time, result, cout, ovf);
                    held = e;
                end
            end else begin
                if (exp_q.size() != 0) begin
                    checks++;
                    errors++;
                    $display("FAIL missing_valid: got out_valid=%b, expected 1", out_valid);
                    void'(exp_q.pop_front());
                end
                compare("hold", dut_out(), held);
            end
        end
    end

    task automatic drive(input logic r, input logic v, input vec_t t);
        @(negedge clk);
        #1;
        rst      = r;
        in_valid = v;
        op       = t.op;
        a        = t.a;
        b        = t.b;
        cin      = t.cin;
        if (v && !r) begin
            exp_t e;
            e.res = t.res;
            e.c   = t.c;
            e.o   = t.o;
`ifdef FA4_ZERO_FLAG_EN
            e.z   = (t.res == '0);
`else
            e.z   = 1'b0;
`endif
            exp_q.push_back(e);
            pushes++;
            $display("t=%0t in op=%b a=%b b=%b cin=%b -> exp res=%b cout=%b ovf=%b",
                     $time, t.op, t.a, t.b, t.cin, t.res, t.c, t.o);
        end
    endtask

    // op, a, b, cin, expected result, cout, ovf
    vec_t vecs[22] = '{
        '{2'b00, 4'b0011, 4'b1100, 1'b0, 4'b1111, 1'b0, 1'b0},
        '{2'b00, 4'b1110, 4'b0011, 1'b0, 4'b0001, 1'b1, 1'b0},
        '{2'b00, 4'b1010, 4'b0101, 1'b1, 4'b0000, 1'b1, 1'b0},
        '{2'b00, 4'b0010, 4'b0100, 1'b1, 4'b0111, 1'b0, 1'b0},
        '{2'b00, 4'b0111, 4'b0001, 1'b0, 4'b1000, 1'b0, 1'b1},
        '{2'b00, 4'b1000, 4'b1000, 1'b0, 4'b0000, 1'b1, 1'b1},
        '{2'b10, 4'b0001, 4'b1111, 1'b1, 4'b1111, 1'b0, 1'b0},
        '{2'b10, 4'b0100, 4'b0000, 1'b0, 4'b1100, 1'b0, 1'b0},
        '{2'b10, 4'b1111, 4'b0101, 1'b1, 4'b0001, 1'b0, 1'b0},
        '{2'b10, 4'b1010, 4'b0000, 1'b0, 4'b0110, 1'b0, 1'b0},
        '{2'b10, 4'b0000, 4'b1111, 1'b1, 4'b0000, 1'b1, 1'b0},
        '{2'b10, 4'b1000, 4'b0011, 1'b0, 4'b1000, 1'b0, 1'b1},
        '{2'b01, 4'b0111, 4'b0011, 1'b0, 4'b0100, 1'b1, 1'b0},
        '{2'b01, 4'b1010, 4'b1100, 1'b0, 4'b1110, 1'b0, 1'b0},
        '{2'b01, 4'b0010, 4'b0001, 1'b0, 4'b0001, 1'b1, 1'b0},
        '{2'b01, 4'b1101, 4'b0111, 1'b0, 4'b0110, 1'b1, 1'b1},
        '{2'b01, 4'b0111, 4'b0011, 1'b1, 4'b0100, 1'b1, 1'b0},
        '{2'b01, 4'b0101, 4'b0101, 1'b0, 4'b0000, 1'b1, 1'b0},
        '{2'b01, 4'b0000, 4'b0001, 1'b0, 4'b1111, 1'b0, 1'b0},
        '{2'b11, 4'b1011, 4'b0101, 1'b1, 4'b1011, 1'b0, 1'b0},
        '{2'b11, 4'b0000, 4'b1111, 1'b1, 4'b0000, 1'b0, 1'b0},
        '{2'b11, 4'b0110, 4'b1001, 1'b0, 4'b0110, 1'b0, 1'b0}
    };

    // Garbage operands used on idle and reset cycles
    vec_t junk  = '{2'b00, 4'b1111, 4'b1111, 1'b1, 4'b0000, 1'b0, 1'b0};
    vec_t op_a  = '{2'b00, 4'b0011, 4'b0100, 1'b0, 4'b0111, 1'b0, 1'b0};
    vec_t op_b  = '{2'b10, 4'b0101, 4'b0000, 1'b0, 4'b1011, 1'b0, 1'b0};

    initial begin
        checks   = 0;
        errors   = 0;
        pushes   = 0;
        pops     = 0;
        mon_en   = 1'b0;
        held     = '0;
        rst      = 1'b1;
        in_valid = 1'b1;
        op       = 2'b00;
        a        = 4'b0101;
        b        = 4'b0011;
        cin      = 1'b1;
        @(posedge clk);
        @(posedge clk);
        mon_en = 1'b1;

        // Back-to-back stream through every directed vector
        for (int i = 0; i < 22; i++) drive(1'b0, 1'b1, vecs[i]);

        // Idle: outputs hold the last result
        for (int i = 0; i < 3; i++) drive(1'b0, 1'b0, junk);

        // Reset mid-stream: the op presented alongside rst is dropped
        drive(1'b0, 1'b1, op_a);
        drive(1'b1, 1'b1, op_b);
        drive(1'b0, 1'b0, junk);
        drive(1'b0, 1'b1, op_b);
        drive(1'b0, 1'b1, vecs[2]);
        drive(1'b0, 1'b0, junk);
        drive(1'b0, 1'b0, junk);
        drive(1'b0, 1'b0, junk);

        checks++;
        if (exp_q.size() != 0 || pops != pushes) begin
            errors++;
            $display("FAIL drain: got %0d outputs with %0d left queued, expected %0d outputs and 0 queued",
                     pops, exp_q.size(), pushes);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
